mem_port_arbiter: RTL and testbench

Shares one single-ported, fixed-latency unified memory between the instruction-fetch stage and the data-memory stage of the 5-stage pipeline. It issues at most one access per cycle and tags every in-flight read so that return data goes to the correct stage. It also produces the fetch stall that drives IF/ID write-disable, and it drops fetch returns that a branch flush has made stale. By default data accesses win; a starvation guard bounds how long fetch can be denied.

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/mem_arb_tag_pipe.sv | 38 +++
 rtl/mem_port_arbiter.sv | 109 ++++++++++
 tb/tb_mem_port_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: read-tag owner, tag record, default latency.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package mem_arb_pkg;

  localparam int DEFAULT_MEM_LAT = 1;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

  localparam tag_t TAG_NONE = '{valid: 1'b0, owner: OWN_IF};

  // A flush invalidates fetch tags only; data tags pass through untouched.
  function automatic tag_t kill_if(tag_t t, logic flush);
    tag_t r;
    r = t;
    if (flush && (t.owner == OWN_IF)) r.valid = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/mem_arb_tag_pipe.sv
// Read-tag shift register that follows each read through the fixed-latency memory.
// Latency: DEPTH cycles from tag_i to tag_o.
// Backpressure: none; advances every cycle, flush kills all fetch tags including the incoming one.
module mem_arb_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = DEFAULT_MEM_LAT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t tag_q [DEPTH];
  tag_t tag_d [DEPTH];

  // Next stage contents: shift by one, applying the fetch kill at every stage.
  always_comb begin
    tag_d[0] = kill_if(tag_i, flush_i);
    for (int i = 1; i < DEPTH; i++) begin
      tag_d[i] = kill_if(tag_q[i-1], flush_i);
    end
  end

  // Tag storage; reset drops everything in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= TAG_NONE;
    end else begin
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= tag_d[i];
    end
  end

  assign tag_o = tag_q[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data stages; optional fetch starvation guard (ARB_STARVE_GUARD_EN).
// Latency: grant is combinational (same cycle); read data returns MEM_LAT cycles after grant.
// Backpressure: loser of a contested cycle sees gnt low (fetch also sees if_stall_o); one access per cycle.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = DEFAULT_MEM_LAT,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_stall_o,
  input  logic              flush_i,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_gnt_o,
  output logic              dm_rvalid_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  logic force_if;
  logic if_gnt;
  logic dm_gnt;
  tag_t new_tag;
  tag_t ret_tag;

  // Data side wins contention unless fetch has been denied long enough.
  assign if_gnt = if_req_i & (~dm_req_i | force_if);
  assign dm_gnt = dm_req_i & ~if_gnt;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_q;
  logic [CNT_W-1:0] starve_d;

  assign force_if = (starve_q == CNT_MAX);

  // Count consecutive fetch denials; any fetch grant or idle fetch cycle clears it.
  always_comb begin
    starve_d = '0;
    if (if_req_i && !if_gnt) begin
      starve_d = (starve_q == CNT_MAX) ? CNT_MAX : starve_q + 1'b1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) starve_q <= '0;
    else         starve_q <= starve_d;
  end
`else
  logic unused_starve_cfg;
  assign unused_starve_cfg = ^STARVE_MAX;
  assign force_if = 1'b0;
`endif

  // Memory port driven from whichever requester holds the grant.
  assign mem_en_o    = if_gnt | dm_gnt;
  assign mem_we_o    = dm_gnt & dm_we_i;
  assign mem_addr_o  = if_gnt ? if_addr_i : dm_addr_i;
  assign mem_wdata_o = dm_gnt ? dm_wdata_i : '0;

  assign if_gnt_o   = if_gnt;
  assign dm_gnt_o   = dm_gnt;
  assign if_stall_o = if_req_i & ~if_gnt;

  // Tag for the access issued this cycle; stores never return data.
  always_comb begin
    new_tag = TAG_NONE;
    if (if_gnt) begin
      new_tag = '{valid: 1'b1, owner: OWN_IF};
    end else if (dm_gnt && !dm_we_i) begin
      new_tag = '{valid: 1'b1, owner: OWN_DM};
    end
  end

  mem_arb_tag_pipe #(
    .DEPTH (MEM_LAT)
  ) u_tag_pipe (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .tag_i   (new_tag),
    .tag_o   (ret_tag)
  );

  // A fetch return landing in a flush cycle is already stale.
  assign if_rvalid_o = ret_tag.valid & (ret_tag.owner == OWN_IF) & ~flush_i;
  assign dm_rvalid_o = ret_tag.valid & (ret_tag.owner == OWN_DM);
  assign if_rdata_o  = mem_rdata_i;
  assign dm_rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: random and directed traffic, reference model predicts returns.
module tb_mem_port_arbiter;

  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int LAT  = 3;
  localparam int SMAX = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req = 1'b0, flush = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [AW-1:0] if_addr = '0, dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic          if_gnt, if_rvalid, if_stall, dm_gnt, dm_rvalid, mem_en, mem_we;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata), .if_stall_o(if_stall),
    .flush_i(flush),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_gnt_o(dm_gnt), .dm_rvalid_o(dm_rvalid), .dm_rdata_o(dm_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int run = 0;
  int if_grants = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t if_q[$];
  exp_t dm_q[$];
  logic [DW-1:0] ref_mem [256];

  function automatic logic [DW-1:0] seed(int a);
    if (a == 5) return 32'hDEADBEEF;
    return 32'(a * 32'h9E3779B9) ^ 32'(a << 7);
  endfunction

  // Environment memory: fixed-latency single port.
  logic [DW-1:0] env_mem [256];
  logic [DW-1:0] rd_pipe [LAT];
  bit            mem_loaded = 1'b0;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= seed(i);
      mem_loaded <= 1'b1;
    end else if (mem_en && mem_we) begin
      env_mem[mem_addr] <= mem_wdata;
    end
    rd_pipe[0] <= (mem_en && !mem_we) ? env_mem[mem_addr] : 32'hBAD0BAD0;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of stimulus; model predicts port activity and queues expected returns.
  task automatic step(input logic ir, input logic [AW-1:0] ia, input logic dr, input logic dw,
                      input logic [AW-1:0] da, input logic [DW-1:0] dd, input logic fl);
    logic e_if, e_dm, e_en, e_we, e_st;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    @(posedge clk);
    #1;
    if_req = ir; if_addr = ia; dm_req = dr; dm_we = dw;
    dm_addr = da; dm_wdata = dd; flush = fl;
    #1;
    e_if   = ir && (!dr || (GUARD && run >= SMAX));
    e_dm   = dr && !e_if;
    e_en   = e_if || e_dm;
    e_we   = e_dm && dw;
    e_st   = ir && !e_if;
    e_addr = e_if ? ia : (e_dm ? da : '0);
    e_wd   = e_dm ? dd : '0;
    check("port", 64'({if_gnt, dm_gnt, mem_en, mem_we, if_stall, (mem_en ? mem_addr : 8'h00), mem_wdata}),
                  64'({e_if, e_dm, e_en, e_we, e_st, e_addr, e_wd}));
    if (if_gnt) if_grants++;
    if (fl) if_q.delete();
    if (e_if && !fl) if_q.push_back('{ref_mem[ia], cyc + LAT});
    if (e_dm && !dw) dm_q.push_back('{ref_mem[da], cyc + LAT});
    if (e_we) ref_mem[da] = dd;
    if (ir && !e_if) run = (run < SMAX) ? run + 1 : SMAX;
    else             run = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; flush = 1'b0;
    if_q.delete();
    dm_q.delete();
    run = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("reset_out", 64'({if_rvalid, dm_rvalid, if_gnt, dm_gnt, mem_en, mem_we, if_stall}), 64'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every return the DUT presents is matched against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (if_rvalid) begin
        if (if_q.size() == 0) check("if_spurious", 64'd1, 64'd0);
        else begin
          e = if_q.pop_front();
          check("if_ret", {32'(cyc), if_rdata}, {32'(e.due), e.data});
        end
      end else if (if_q.size() != 0 && if_q[0].due <= cyc) begin
        e = if_q.pop_front();
        check("if_missing", 64'd0, 64'd1);
      end
      if (dm_rvalid) begin
        if (dm_q.size() == 0) check("dm_spurious", 64'd1, 64'd0);
        else begin
          e = dm_q.pop_front();
          check("dm_ret", {32'(cyc), dm_rdata}, {32'(e.due), e.data});
        end
      end else if (dm_q.size() != 0 && dm_q[0].due <= cyc) begin
        e = dm_q.pop_front();
        check("dm_missing", 64'd0, 64'd1);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = seed(i);
    do_reset(3);

    // Single fetch from 0x05.
    step(1'b1, 8'h05, 1'b0, 1'b0, '0, '0, 1'b0);
    idle(LAT + 1);

    // Sustained contention: fetch forced through every SMAX+1 cycles with the guard.
    if_grants = 0;
    for (int i = 0; i < 15; i++) step(1'b1, 8'(8'h40 + i), 1'b1, 1'b0, 8'h10, '0, 1'b0);
    check("contention_if_grants", 64'(if_grants), GUARD ? 64'd3 : 64'd0);
    idle(LAT + 1);

    // Store then load the same word.
    step(1'b0, '0, 1'b1, 1'b1, 8'h20, 32'h12345678, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 8'h20, '0, 1'b0);
    idle(LAT + 1);

    // Back-to-back fetches with a flush on the second, then a data load.
    step(1'b1, 8'h30, 1'b0, 1'b0, '0, '0, 1'b0);
    step(1'b1, 8'h31, 1'b0, 1'b0, '0, '0, 1'b1);
    step(1'b1, 8'h32, 1'b0, 1'b0, '0, '0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 8'h33, '0, 1'b0);
    idle(LAT + 1);

    // Randomized mixed traffic.
    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom,
           ($urandom_range(0, 9) == 0));
    end
    idle(LAT + 1);

    // Reset with two reads in flight, then contention restarts the denial count.
    step(1'b1, 8'h50, 1'b1, 1'b0, 8'h51, '0, 1'b0);
    step(1'b1, 8'h52, 1'b1, 1'b0, 8'h53, '0, 1'b0);
    do_reset(LAT + 1);
    idle(1);
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h60 + i), 1'b1, 1'b0, 8'h11, '0, 1'b0);
    idle(LAT + 2);

    check("if_q_drained", 64'(if_q.size()), 64'd0);
    check("dm_q_drained", 64'(dm_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
